// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [7:0] DEC_MAX  = 8'd99;
  localparam logic [1:0] SRC_DATA = 2'd0;
  localparam logic [1:0] SRC_STAT = 2'd1;
  localparam logic [1:0] SRC_ERR  = 2'd2;

  // Round-robin successor over the three sources; an out-of-range index restarts at data.
  function automatic logic [1:0] next_src(input logic [1:0] idx);
    return (idx == SRC_ERR) ? SRC_DATA : idx + 2'd1;
  endfunction

  // A byte is shown as two decimal digits, so clamp it to 99.
  function automatic logic [7:0] sat_byte(input logic [7:0] b);
    return (b > DEC_MAX) ? DEC_MAX : b;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin pick: scanning starts one past the last grant.
module rr_arbiter3
  import display_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_last,
  output logic [2:0] o_grant,
  output logic [1:0] o_idx,
  output logic       o_valid
);

  logic [1:0] w_c0;
  logic [1:0] w_c1;
  logic [1:0] w_c2;

  assign w_c0    = next_src(i_last);
  assign w_c1    = next_src(w_c0);
  assign w_c2    = next_src(w_c1);
  assign o_valid = |i_req;

  always_comb begin
    o_grant = 3'b000;
    o_idx   = w_c0;
    if (i_req[w_c0]) begin
      o_grant[w_c0] = 1'b1;
      o_idx         = w_c0;
    end else if (i_req[w_c1]) begin
      o_grant[w_c1] = 1'b1;
      o_idx         = w_c1;
    end else if (i_req[w_c2]) begin
      o_grant[w_c2] = 1'b1;
      o_idx         = w_c2;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the 4-digit display among data, status and error requesters,
// with a hold/blank cadence and a free-running digit-scan prescaler.
module display_scheduler
  import display_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int SCAN_DIV    = 50_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  output logic [2:0]  ack,
  output logic [15:0] disp_a,
  output logic        blank,
  output logic        scan_en,
  output logic        sat,
  output logic        busy,
  output state_e      dbg_state
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  state_e        r_state;
  state_e        w_next_state;
  logic [HW-1:0] r_hold_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_last;
  logic [2:0]    r_ack;
  logic [15:0]   r_disp;
  logic          r_sat;
  logic          r_busy;

  logic [2:0]    w_grant;
  logic [1:0]    w_grant_idx;
  logic          w_valid;
  logic          w_take;
  logic          w_show_end;
  logic          w_gap_end;
  logic [15:0]   w_sel_val;
  logic [15:0]   w_sat_val;
  logic          w_sat_flag;

  rr_arbiter3 u_arb (
    .i_req   (req),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_valid (w_valid)
  );

  // State register: reset parks in GAP with a zero count so the next edge lands in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= GAP;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_next_state = SHOW;
      SHOW:    if (r_hold_cnt == '0) w_next_state = GAP;
      GAP:     if (r_gap_cnt == '0) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_take     = 1'b0;
    w_show_end = 1'b0;
    w_gap_end  = 1'b0;
    blank      = 1'b0;
    case (r_state)
      IDLE: w_take = w_valid;
      SHOW: w_show_end = (r_hold_cnt == '0);
      GAP: begin
        blank     = 1'b1;
        w_gap_end = (r_gap_cnt == '0);
      end
      default: blank = 1'b1;
    endcase
  end

  // Each counter loads on entry to its state and holds at zero until the exit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      if (w_take)
        r_hold_cnt <= HOLD_LOAD;
      else if (r_state == SHOW && r_hold_cnt != '0)
        r_hold_cnt <= r_hold_cnt - HW'(1);
      if (w_show_end)
        r_gap_cnt <= GAP_LOAD;
      else if (r_state == GAP && r_gap_cnt != '0)
        r_gap_cnt <= r_gap_cnt - GW'(1);
    end
  end

  always_comb begin
    case (w_grant_idx)
      SRC_DATA: w_sel_val = val0;
      SRC_STAT: w_sel_val = val1;
      SRC_ERR:  w_sel_val = val2;
      default:  w_sel_val = val0;
    endcase
  end

  assign w_sat_val  = {sat_byte(w_sel_val[15:8]), sat_byte(w_sel_val[7:0])};
  assign w_sat_flag = (w_sel_val[15:8] > DEC_MAX) || (w_sel_val[7:0] > DEC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack  <= 3'b000;
      r_disp <= 16'h0000;
      r_sat  <= 1'b0;
      r_busy <= 1'b0;
      r_last <= SRC_ERR;
    end else begin
      r_ack <= w_take ? w_grant : 3'b000;
      if (w_take) begin
        r_disp <= w_sat_val;
        r_sat  <= w_sat_flag;
        r_last <= w_grant_idx;
        r_busy <= 1'b1;
      end else if (w_gap_end) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Digit-scan prescaler runs regardless of the display state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_scan_cnt <= '0;
    else if (r_scan_cnt == SCAN_LAST) r_scan_cnt <= '0;
    else                          r_scan_cnt <= r_scan_cnt + SW'(1);
  end

  assign scan_en   = (r_scan_cnt == SCAN_LAST);
  assign ack       = r_ack;
  assign disp_a    = r_disp;
  assign sat       = r_sat;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: expected grants are queued at stimulus
// time and matched by a monitor whenever an ack pulse appears.
module tb_display_scheduler;
  import display_pkg::*;

  localparam int HOLD_N  = 8;
  localparam int GAP_N   = 3;
  localparam int SCAN_N  = 4;
  localparam int SPACING = HOLD_N + GAP_N + 1;
  localparam int BOUND   = 4 * SPACING;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  req   = 3'b000;
  logic [15:0] val0  = '0;
  logic [15:0] val1  = '0;
  logic [15:0] val2  = '0;
  logic [2:0]  ack;
  logic [15:0] disp_a;
  logic        blank;
  logic        scan_en;
  logic        sat;
  logic        busy;
  state_e      dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int scan_edges = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;

  display_scheduler #(
    .HOLD_CYCLES (HOLD_N),
    .GAP_CYCLES  (GAP_N),
    .SCAN_DIV    (SCAN_N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .val0      (val0),
    .val1      (val1),
    .val2      (val2),
    .ack       (ack),
    .disp_a    (disp_a),
    .blank     (blank),
    .scan_en   (scan_en),
    .sat       (sat),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and cycle/edge counters
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan_edges <= 0;
    else        scan_edges <= scan_edges + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input logic [2:0] a, input logic s, input logic [15:0] d);
    exp_q.push_back({a, s, d});
  endfunction

  task automatic wait_ack(input string name, output int at);
    at = -1;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (ack != 3'b000) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < BOUND) begin
      n++;
      @(negedge clk);
    end
    if (n >= BOUND) check({name, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  // Scoreboard monitor: every ack pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && ack != 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {29'd0, ack}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("grant_ack",  {29'd0, ack}, {29'd0, mon_e[19:17]});
        check("grant_sat",  {31'd0, sat}, {31'd0, mon_e[16]});
        check("grant_disp", {16'd0, disp_a}, {16'd0, mon_e[15:0]});
        check("grant_busy", {31'd0, busy}, 32'd1);
      end
    end
  end

  // Scan-enable monitor: one-cycle pulse when the edge count since reset is 3 mod 4.
  always @(negedge clk) begin
    if (rst_n)
      check("scan_en", {31'd0, scan_en}, {31'd0, (scan_edges % SCAN_N) == (SCAN_N - 1)});
  end

  initial begin
    int a1, a2, a3, a4, c0, n;

    // Reset values
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_disp",  {16'd0, disp_a}, 32'h0);
    check("rst_blank", {31'd0, blank}, 32'd1);
    check("rst_ack",   {29'd0, ack}, 32'd0);
    check("rst_sat",   {31'd0, sat}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_scan",  {31'd0, scan_en}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, GAP});

    // Single request right after reset: grant lands on the 2nd edge
    val0 = 16'h0C22;
    req  = 3'b001;
    push(3'b001, 1'b0, 16'h0C22);
    rst_n = 1'b1;
    c0 = cyc;
    wait_ack("single", a1);
    req = 3'b000;
    check("first_grant_latency", a1 - c0, 32'd2);
    n = 0;
    while (blank == 1'b0 && n < BOUND) begin
      n++;
      @(negedge clk);
      if (n == 1) check("ack_one_cycle", {29'd0, ack}, 32'd0);
      check("show_disp", {16'd0, disp_a}, 32'h0C22);
    end
    check("show_len", n, HOLD_N);
    n = 0;
    while (blank == 1'b1 && n < BOUND) begin
      n++;
      check("gap_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    check("gap_len", n, GAP_N);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_disp_kept", {16'd0, disp_a}, 32'h0C22);

    // Saturation: status clamps (120 -> 99), error exactly 99 does not
    val1 = 16'h7805;
    val2 = 16'h6363;
    req  = 3'b110;
    push(3'b010, 1'b1, 16'h6305);
    push(3'b100, 1'b0, 16'h6363);
    wait_ack("sat1", a1);
    req[1] = 1'b0;
    wait_ack("sat2", a2);
    req = 3'b000;
    check("sat_spacing", a2 - a1, SPACING);
    wait_idle("sat");

    // Round-robin with all three persistent
    val0 = 16'h0102;
    val1 = 16'h6400;
    val2 = 16'h0063;
    push(3'b001, 1'b0, 16'h0102);
    push(3'b010, 1'b1, 16'h6300);
    push(3'b100, 1'b0, 16'h0063);
    push(3'b001, 1'b0, 16'h0102);
    req = 3'b111;
    wait_ack("rr1", a1);
    wait_ack("rr2", a2);
    wait_ack("rr3", a3);
    wait_ack("rr4", a4);
    req = 3'b000;
    check("rr_spacing_12", a2 - a1, SPACING);
    check("rr_spacing_23", a3 - a2, SPACING);
    check("rr_spacing_34", a4 - a3, SPACING);
    wait_idle("rr");

    // Request raised mid-SHOW is served on the first IDLE edge
    val0 = 16'h0304;
    req  = 3'b001;
    push(3'b001, 1'b0, 16'h0304);
    wait_ack("late1", a1);
    req = 3'b000;
    repeat (HOLD_N / 2) @(negedge clk);
    val2 = 16'h5A5A;
    req  = 3'b100;
    push(3'b100, 1'b0, 16'h5A5A);
    wait_ack("late2", a2);
    req = 3'b000;
    check("late_req_latency", a2 - a1, SPACING);
    wait_idle("late");

    // Reset mid-hold aborts immediately; next grant starts at source 0
    val1 = 16'h1199;
    req  = 3'b010;
    push(3'b010, 1'b1, 16'h1163);
    wait_ack("pre_rst", a1);
    req = 3'b000;
    repeat (HOLD_N / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_disp",  {16'd0, disp_a}, 32'h0);
    check("midrst_blank", {31'd0, blank}, 32'd1);
    check("midrst_busy",  {31'd0, busy}, 32'd0);
    check("midrst_sat",   {31'd0, sat}, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, {30'd0, GAP});
    val0 = 16'h2222;
    req  = 3'b011;
    push(3'b001, 1'b0, 16'h2222);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    wait_ack("post_rst1", a1);
    req = 3'b010;
    check("post_rst_latency", a1 - c0, 32'd2);
    push(3'b010, 1'b1, 16'h1163);
    wait_ack("post_rst2", a2);
    req = 3'b000;
    check("post_rst_spacing", a2 - a1, SPACING);
    wait_idle("post_rst");

    repeat (2) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-shares the 4-digit seven-segment display between three requesters: received data, link status and error code. It sits in front of the digit-multiplexing display driver. It picks one pending request using round-robin, latches and saturates its value, and holds it on the display for a fixed time. It then blanks the display briefly before serving the next request, and supplies the driver's digit-scan enable.

## Interface
- `HOLD_CYCLES`, default 50_000_000: cycles a granted value stays on the display (≥2).
- `GAP_CYCLES`, default 5_000_000: blank cycles between two displayed values (≥1).
- `SCAN_DIV`, default 50_000: scan-enable period in cycles (≥2).

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `req` input 3: level requests; bit 0 is data, bit 1 is status, bit 2 is error.
- `val0`, `val1`, `val2` input 16 each: display word per requester. Each is two bytes, and each byte is shown as two decimal digits.
- `ack` output 3: one-cycle grant pulse, one-hot.
- `disp_a` output 16: word to the display driver.
- `blank` output 1: driver forces all segments off while high.
- `scan_en` output 1: one-cycle pulse every `SCAN_DIV` cycles; the driver advances one digit per pulse.
- `sat` output 1: set when the latched value had a byte >99.
- `busy` output 1: high in SHOW and GAP.

## Operation
- FSM states: IDLE, SHOW, GAP.
- **IDLE**
  - `disp_a` keeps its last value and `blank` is 0.
  - If `req` is nonzero, grant the first set bit scanning upward, starting at index `last + 1` (mod 3).
  - At that edge: pulse `ack[i]`, latch `val_i` (saturated), set `last = i`, load the hold counter, and go to SHOW.
- **SHOW**
  - Hold the counter down over `HOLD_CYCLES` cycles, then go to GAP.
  - `req` is ignored and no `ack` is issued.
- **GAP**
  - `blank` is 1 and `disp_a` is unchanged.
  - Count `GAP_CYCLES` cycles, then go to IDLE.
- Saturation is applied per byte:
  - `disp_a[15:8] = min(val[15:8], 99)` and `disp_a[7:0] = min(val[7:0], 99)`.
  - `sat` is the OR of both clamps and is updated only on grant.
- Requesters hold `req` until they see `ack`. `req` dropped before a grant is simply not served.
- The `req` bit of the granted source may remain high after `ack`; it then competes again after GAP.
- Round-robin guarantees that each persistent requester is served within 3 grants.
- `scan_en` prescaler:
  - Free-running and independent of the FSM.
  - It keeps running during `blank`.
  - The counter runs 0..`SCAN_DIV`-1 and the pulse fires at `SCAN_DIV`-1.

## Timing
- Reset values:
  - `disp_a` = 0, `blank` = 1, `ack` = 0, `sat` = 0, `busy` = 0, `scan_en` = 0.
  - State is GAP with a zero count, so the first cycle after reset drops to IDLE.
  - `last` = 2, so the first arbitration starts at source 0.
  - Prescaler = 0.
- Grant latency: `req` sampled high in IDLE at edge N gives `ack`, the new `disp_a`, `sat` and `busy` all valid after edge N.
- `ack` is high for exactly the cycle after edge N.
- The display shows the value for exactly `HOLD_CYCLES` cycles and is blank for exactly `GAP_CYCLES` cycles.
- Minimum spacing between two `ack` pulses is `HOLD_CYCLES + GAP_CYCLES + 1` cycles.
- Simultaneous requests resolve in the same cycle by the round-robin order; there is no extra latency.
- `rst_n` asserted mid-SHOW or mid-GAP aborts immediately to the reset values. The display blanks asynchronously.
- On reset deassertion, the first grant is possible on the 2nd edge.
- Counter widths use `$clog2` of their parameter, with no wrap. Both counters reload on entry to their state.

## Structure
- A shared package `display_pkg` holds:
  - the state enum (IDLE/SHOW/GAP);
  - the constant `DEC_MAX = 8'd99`;
  - the source index constants `SRC_DATA=0`, `SRC_STAT=1`, `SRC_ERR=2`.
- One natural sub-module, `rr_arbiter3`: combinational round-robin pick from `req` and `last`, giving a one-hot `grant` and a `valid` flag.
- The prescaler, FSM and saturation logic stay in the top module.

## Test plan
- **Reset and single request:** release reset, `req`=001, `val0`=0x0C22 → `ack`=001 for one cycle. `disp_a`=0x0C22, `sat`=0 and `blank`=0 for `HOLD_CYCLES`, then `blank`=1 for `GAP_CYCLES`.
- **Saturation:** `val1`=0x7805 (120,5) → `disp_a`=0x6305, `sat`=1. Next grant with `val2`=0x6363 → `disp_a`=0x6363, `sat`=0.
- **Round-robin:** hold `req`=111 → grant order is 001, 010, 100, 001. `ack` spacing is exactly `HOLD_CYCLES+GAP_CYCLES+1`.
- **Requests during SHOW/GAP:** raise `req[2]` mid-SHOW → no `ack` until IDLE, then `ack`=100 on the first IDLE edge.
- **Reset mid-hold:** assert `rst_n`=0 halfway through SHOW → `disp_a`=0 and `blank`=1 immediately, `busy`=0. After release, the first grant goes to source 0.
- **Scan enable:** with `SCAN_DIV`=4, `scan_en` pulses at cycles 4, 8, 12… after reset, continues uninterrupted through SHOW/GAP transitions, and each pulse is one cycle wide.
